// File: rtl/des_pkg.sv
// Shared DES block/half-word definitions used by the splitter and by the joiner.
package des_pkg;

   localparam int HALF_W  = 32;
   localparam int BLOCK_W = 64;

   typedef enum logic {
      ST_HI = 1'b0,
      ST_LO = 1'b1
   } state_e;

   // swap=1 applies the final DES swap (R16 || L16); swap=0 is the plain inverse split.
   function automatic logic [BLOCK_W-1:0] join_halves(
      input logic [HALF_W-1:0] hi,
      input logic [HALF_W-1:0] lo,
      input logic              swap
   );
      return swap ? {lo, hi} : {hi, lo};
   endfunction

endpackage

// File: rtl/des_block_fifo.sv
// Generic BLOCK_W x DEPTH synchronous FIFO; push and pop may coincide when full or empty.
module des_block_fifo
   import des_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push,
   input  logic [BLOCK_W-1:0] push_data,
   input  logic               pop,
   output logic [BLOCK_W-1:0] head,
   output logic               full,
   output logic               empty
);

   localparam int AW = $clog2(DEPTH);

   logic [BLOCK_W-1:0] mem_q [DEPTH];
   logic [BLOCK_W-1:0] mem_d [DEPTH];
   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic               do_push;
   logic               do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/des_block_join.sv
// Reassembles 64-bit DES blocks from a hi/lo 32-bit half-word stream into an output FIFO,
// flagging framing errors and counting emitted blocks.
module des_block_join
   import des_pkg::*;
#(
   parameter int SWAP  = 1,
   parameter int DEPTH = 2,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [HALF_W-1:0]  s_word,
   input  logic               s_first,
   input  logic               s_valid,
   output logic               s_ready,
   output logic [BLOCK_W-1:0] m_block,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               err,
   output logic [CNT_W-1:0]   block_count
);

   state_e             state_q, state_d;
   logic [HALF_W-1:0]  hi_q, hi_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               beat;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [BLOCK_W-1:0] push_data;

   assign m_valid     = !empty;
   assign err         = err_q;
   assign block_count = cnt_q;
   assign push_data   = join_halves(hi_q, s_word, SWAP != 0);

   always_comb begin
      pop     = m_valid && m_ready;
      // In LO a beat may complete a block, so it needs a free slot or a same-cycle pop.
      s_ready = !rst && ((state_q == ST_HI) || !full || pop);
      beat    = s_valid && s_ready;
      state_d = state_q;
      hi_d    = hi_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      push    = 1'b0;
      if (beat) begin
         case (state_q)
            ST_HI: begin
               if (s_first) begin
                  hi_d    = s_word;
                  state_d = ST_LO;
               end else begin
                  err_d = 1'b1;
               end
            end
            ST_LO: begin
               if (s_first) begin
                  err_d = 1'b1;
                  hi_d  = s_word;
               end else begin
                  push    = 1'b1;
                  cnt_d   = cnt_q + 1'b1;
                  state_d = ST_HI;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HI;
         hi_q    <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   des_block_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (m_block),
      .full      (full),
      .empty     (empty)
   );

endmodule

// File: tb/tb_des_block_join.sv
// Directed bench for des_block_join: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_des_block_join;

   localparam int DEPTH = 2;
   localparam int CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_word = '0;
   logic        s_first = 1'b0;
   logic        s_valid = 1'b0;
   logic        m_ready = 1'b0;

   logic              s_ready_a, m_valid_a, err_a;
   logic [63:0]       m_block_a;
   logic [CNT_W-1:0]  count_a;
   logic              s_ready_b, m_valid_b, err_b;
   logic [63:0]       m_block_b;
   logic [CNT_W-1:0]  count_b;

   int checks = 0;
   int failures = 0;

   des_block_join #(.SWAP(1), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_swap (
      .clk(clk), .rst(rst), .s_word(s_word), .s_first(s_first), .s_valid(s_valid),
      .s_ready(s_ready_a), .m_block(m_block_a), .m_valid(m_valid_a), .m_ready(m_ready),
      .err(err_a), .block_count(count_a)
   );

   des_block_join #(.SWAP(0), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut_plain (
      .clk(clk), .rst(rst), .s_word(s_word), .s_first(s_first), .s_valid(s_valid),
      .s_ready(s_ready_b), .m_block(m_block_b), .m_valid(m_valid_b), .m_ready(m_ready),
      .err(err_b), .block_count(count_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: expected FIFO contents as queues of finished blocks.
   logic [63:0] q_swap[$];
   logic [63:0] q_plain[$];
   bit          pend = 0;
   logic [31:0] hi_m = '0;
   int          cnt_m = 0;
   bit          err_m = 0;
   bit          model_ok = 0;

   function automatic bit exp_ready();
      return !rst && (!pend || q_swap.size() < DEPTH || (q_swap.size() > 0 && m_ready));
   endfunction

   always @(posedge clk) begin : model
      bit beat;
      bit pop;
      bit push;
      if (rst) begin
         q_swap.delete();
         q_plain.delete();
         pend     = 0;
         hi_m     = '0;
         cnt_m    = 0;
         err_m    = 0;
         model_ok = 1;
      end else begin
         beat  = s_valid && exp_ready();
         pop   = (q_swap.size() > 0) && m_ready;
         push  = 0;
         err_m = 0;
         if (beat) begin
            if (s_first) begin
               if (pend) err_m = 1;
               hi_m = s_word;
               pend = 1;
            end else if (!pend) begin
               err_m = 1;
            end else begin
               push  = 1;
               pend  = 0;
               cnt_m = (cnt_m + 1) % (1 << CNT_W);
            end
         end
         if (pop) begin
            void'(q_swap.pop_front());
            void'(q_plain.pop_front());
         end
         if (push) begin
            q_swap.push_back({s_word, hi_m});
            q_plain.push_back({hi_m, s_word});
         end
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("m_valid_swap", m_valid_a, q_swap.size() > 0);
         chk("m_valid_plain", m_valid_b, q_plain.size() > 0);
         if (q_swap.size() > 0) chk("m_block_swap", m_block_a, q_swap[0]);
         if (q_plain.size() > 0) chk("m_block_plain", m_block_b, q_plain[0]);
         chk("err_swap", err_a, err_m);
         chk("err_plain", err_b, err_m);
         chk("count_swap", count_a, cnt_m);
         chk("count_plain", count_b, cnt_m);
         chk("s_ready_swap", s_ready_a, exp_ready());
         chk("s_ready_plain", s_ready_b, exp_ready());
      end
   end

   // Drives one beat and returns 2 time units after the edge that accepted it.
   task automatic drive_beat(input logic [31:0] w, input bit f);
      int n;
      bit r;
      n = 0;
      s_word  = w;
      s_first = f;
      s_valid = 1'b1;
      do begin
         @(negedge clk);
         #4;
         r = s_ready_a;
         @(posedge clk);
         n++;
      end while (!r && n < 100);
      if (!r) begin
         checks++;
         failures++;
         $display("FAIL beat_timeout actual=stalled required=accepted word=%h", w);
      end
      #2;
      s_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      chk("rst_m_block", m_block_a, 64'h0);
      chk("rst_m_valid", m_valid_a, 1'b0);
      chk("rst_count", count_a, 0);

      // Basic join in both SWAP settings
      m_ready = 1'b1;
      drive_beat(32'h01234567, 1);
      drive_beat(32'h89ABCDEF, 0);
      chk("basic_valid", m_valid_a, 1'b1);
      chk("basic_swap", m_block_a, 64'h89ABCDEF01234567);
      chk("basic_plain", m_block_b, 64'h0123456789ABCDEF);
      chk("basic_count", count_a, 1);
      idle(1);

      // Backpressure with DEPTH=2
      m_ready = 1'b0;
      drive_beat(32'h11111111, 1);
      drive_beat(32'h22222222, 0);
      drive_beat(32'h33333333, 1);
      drive_beat(32'h44444444, 0);
      drive_beat(32'h55555555, 1);
      fork
         drive_beat(32'h66666666, 0);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("bp_stall_ready", s_ready_a, 1'b0);
            end
            @(posedge clk);
            #2;
            m_ready = 1'b1;
         end
      join
      chk("bp_head_after_bypass", m_block_a, 64'h4444444433333333);
      chk("bp_count", count_a, 4);
      idle(3);
      chk("bp_drained", m_valid_a, 1'b0);

      // Framing errors
      drive_beat(32'hDEADBEEF, 0);
      chk("err_hi_pulse", err_a, 1'b1);
      chk("err_hi_nopush", count_a, 4);
      drive_beat(32'h12345678, 1);
      drive_beat(32'hAAAA5555, 1);
      chk("err_lo_pulse", err_a, 1'b1);
      drive_beat(32'h5555AAAA, 0);
      chk("resync_block", m_block_a, 64'h5555AAAAAAAA5555);
      chk("resync_err_clear", err_a, 1'b0);
      chk("resync_count", count_a, 5);
      idle(2);

      // Reset mid-block with one block queued
      m_ready = 1'b0;
      drive_beat(32'h0BADF00D, 1);
      drive_beat(32'h0C0FFEE0, 0);
      drive_beat(32'h77777777, 1);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      chk("midrst_valid", m_valid_a, 1'b0);
      chk("midrst_count", count_a, 0);
      m_ready = 1'b1;
      drive_beat(32'hCAFEF00D, 1);
      drive_beat(32'h12345678, 0);
      chk("midrst_block", m_block_a, 64'h12345678CAFEF00D);
      chk("midrst_count1", count_a, 1);

      // Counter wrap: 17 blocks since reset with a 4-bit counter
      for (int i = 0; i < 16; i++) begin
         drive_beat(32'hA0000000 + i, 1);
         drive_beat(32'hB0000000 + i, 0);
      end
      chk("wrap_count", count_a, 1);
      chk("wrap_err", err_a, 1'b0);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/des_block_join.md
# des_block_join

Reassembles 64-bit DES blocks from a 32-bit half-word stream: the inverse of the 64→32 L/R split at the input of the round datapath. It sits at the output of the round engine, or of any 32-bit-wide transport. It accepts high/low halves over a valid/ready handshake, optionally applies the final DES swap (R16‖L16), and buffers completed blocks in a small output FIFO. It also flags framing errors and counts emitted blocks.

## Interface
Parameters:
- SWAP, 1, 1: block = {lo, hi} (final DES swap, R16‖L16). 0: block = {hi, lo} (plain inverse of the split).
- DEPTH, 2, output FIFO entries; power of two, ≥ 2.
- CNT_W, 16, width of block_count.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_word  in  32  half-word; high half (L) first, then low half (R).
- s_first  in  1  marks the high half of a block.
- s_valid  in  1  s_word/s_first valid.
- s_ready  out  1  block accepts the beat this cycle.
- m_block  out  64  assembled block at FIFO head.
- m_valid  out  1  m_block valid.
- m_ready  in  1  consumer takes m_block this cycle.
- err  out  1  one-cycle pulse on a framing error.
- block_count  out  CNT_W  number of blocks pushed since reset; wraps.

## Operation
- Beat transfer: s_valid & s_ready at a rising edge. Block transfer: m_valid & m_ready at a rising edge.
- FSM states:
  - HI: waiting for the high half.
  - LO: high half held in hi_reg, waiting for the low half.
- HI, beat with s_first=1: hi_reg ← s_word; go to LO.
- HI, beat with s_first=0: beat dropped; err pulses; stay in HI.
- LO, beat with s_first=0: form the block from hi_reg and s_word per SWAP; push to the FIFO; block_count += 1; go to HI.
- LO, beat with s_first=1: the pending half is discarded; err pulses; hi_reg ← s_word; stay in LO (resynchronise).
- s_ready (combinational from state and FIFO status only, never from s_valid):
  - HI: s_ready = 1.
  - LO: s_ready = !full | (m_valid & m_ready).
- FIFO:
  - m_valid = !empty; m_block = head entry.
  - Simultaneous push and pop are allowed when full, and when empty (data passes through the register, not combinationally).
- block_count wraps from 2^CNT_W−1 to 0 without flagging.
- No inputs are checked while rst is high; s_ready is forced to 0 during rst.

## Timing
- Reset values (after a reset edge): state HI, hi_reg 0, FIFO empty, m_valid 0, m_block 0, err 0, block_count 0.
- Reset mid-operation discards the held half and all FIFO contents; nothing is emitted for them.
- Latency: low half accepted at edge N with the FIFO empty → m_valid=1 with that block in the cycle after edge N (1 cycle).
- No combinational path from s_* to m_*, or from m_ready to s_ready except through the LO-state full-bypass term.
- Throughput: one block per 2 input cycles; the FIFO never limits a consumer that holds m_ready=1.
- err is registered and asserted for exactly the cycle after the offending beat edge.
- m_block stays stable while m_valid=1 and m_ready=0.

## Structure
- Shared package des_pkg holds:
  - HALF_W = 32 and BLOCK_W = 64, shared with the splitter.
  - The state typedef {ST_HI, ST_LO}.
  - The function join_halves(hi, lo, swap).
- Sub-module des_block_fifo: a generic BLOCK_W × DEPTH synchronous FIFO with full/empty flags and simultaneous push/pop. The FSM, error logic and counter stay in the top module.

## Test plan
- SWAP=1: beats 0x01234567 (first=1), then 0x89ABCDEF (first=0), m_ready=1 → m_block=0x89ABCDEF01234567, m_valid one cycle after the second beat; block_count=1. Same beats with SWAP=0 → 0x0123456789ABCDEF.
- Backpressure, DEPTH=2: hold m_ready=0 and send 3 blocks → s_ready drops in LO after 2 pushes, and the third low half stalls. Raise m_ready → blocks drain in order and the third is pushed in the same cycle as the first pop.
- Framing errors:
  - In HI, beat 0xDEADBEEF with first=0 → err pulse, no push, still HI.
  - In LO, a new first=1 beat 0xAAAA5555 → err pulse, old half discarded. The next beat 0x5555AAAA yields 0x5555AAAAAAAA5555 (SWAP=1).
- Reset mid-block: rst after the high half and with 1 block queued → m_valid=0, block_count=0. The next complete pair produces a correct block.
- Counter wrap: CNT_W=4, 17 blocks → block_count reads 1; no err.
